sd_forward_mc: RTL and testbench



---
 rtl/sd_forward_pkg.sv | 24 ++
 rtl/sd_desc_queue.sv | 69 ++++++
 rtl/sd_forward_mc.sv | 226 ++++++++++++++++++++++
 tb/tb_sd_forward_mc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_forward_pkg.sv
// Shared types for the multi-channel sideband store-and-forward queue.
// Holds the sideband descriptor layout and the write FSM state encoding.
package sd_forward_pkg;

    localparam int EXP_W    = 6;
    localparam int SYMBOL_W = 4;
    localparam int SLOT_W   = 8;
    localparam int FRAME_W  = 10;
    localparam int SB_WIDTH = FRAME_W + SLOT_W + SYMBOL_W + EXP_W;

    typedef struct packed {
        logic [FRAME_W-1:0]  frame;
        logic [SLOT_W-1:0]   slot;
        logic [SYMBOL_W-1:0] symbol;
        logic [EXP_W-1:0]    exp;
    } sb_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACTIVE,
        WR_DISCARD
    } wr_state_t;

endpackage

// File: rtl/sd_desc_queue.sv
// Per-channel descriptor ring: storage, head/tail pointers and used count.
// Look-ahead read port exists only when SD_FORWARD_MC_PRE_EN is defined.
module sd_desc_queue
    import sd_forward_pkg::*;
#(
    parameter int DEPTH     = 5,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk_wr,
    input  logic                 rst_n,
    input  logic                 restart,
    input  logic                 wr_en,
    input  sb_t                  wr_data,
    input  logic                 commit,
    input  logic                 pop,
    output sb_t                  head_data,
`ifdef SD_FORWARD_MC_PRE_EN
    output sb_t                  pre_data,
`endif
    output logic [CNT_WIDTH-1:0] used
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    sb_t                  mem [DEPTH];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_WIDTH-1:0] used_q;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // The open descriptor lands in the tail slot; it only becomes
    // visible once commit advances the tail.
    always_ff @(posedge clk_wr) begin
        if (wr_en) mem[tail_q] <= wr_data;
    end

    // Pointer and occupancy bookkeeping; restart empties the ring.
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            used_q <= '0;
        end else if (restart) begin
            head_q <= '0;
            tail_q <= '0;
            used_q <= '0;
        end else begin
            if (commit) tail_q <= nxt(tail_q);
            if (pop) head_q <= nxt(head_q);
            if (commit && !pop) begin
                used_q <= used_q + 1'b1;
            end else if (pop && !commit) begin
                used_q <= used_q - 1'b1;
            end
        end
    end

    assign head_data = mem[head_q];
    assign used      = used_q;

`ifdef SD_FORWARD_MC_PRE_EN
    assign pre_data = mem[nxt(head_q)];
`endif

endmodule

// File: rtl/sd_forward_mc.sv
// Multi-channel sideband store-and-forward: write FSM, channel muxes, counters.
// Define SD_FORWARD_MC_PRE_EN to enable the dout_sb_pre look-ahead output.
module sd_forward_mc
    import sd_forward_pkg::*;
#(
    parameter int CHAN_QTY    = 2,
    parameter int CHAN_WIDTH  = 1,
    parameter int DEPTH       = 5,
    parameter int CNT_WIDTH   = 3,
    parameter int FULL_THRES  = 0,
    parameter int EMPTY_THRES = 0
) (
    input  logic                          clk_wr,
    input  logic                          rst_n,
    input  logic                          din_restart,
    input  logic [CHAN_WIDTH-1:0]         din_chan,
    input  logic                          din_sop,
    input  logic                          din_eop,
    input  logic                          din_valid,
    input  sb_t                           din_sb,
    output logic                          din_ready,
    input  logic [CHAN_WIDTH-1:0]         dout_chan,
    input  logic                          dout_ready,
    input  logic                          dout_drop,
    input  logic                          dout_repeat,
    output logic                          dout_valid,
    output sb_t                           dout_sb,
    output sb_t                           dout_sb_pre,
    output logic [CHAN_WIDTH-1:0]         dout_chan_o,
    output logic [31:0]                   overflow_cnt,
    output logic [31:0]                   underflow_cnt,
    output logic [CHAN_QTY*CNT_WIDTH-1:0] bloc_used,
    output logic [CHAN_QTY-1:0]           bloc_full,
    output logic [CHAN_QTY-1:0]           bloc_empty
);

    localparam logic [CNT_WIDTH-1:0] FULL_LVL  = CNT_WIDTH'(DEPTH - FULL_THRES);
    localparam logic [CNT_WIDTH-1:0] EMPTY_LVL = CNT_WIDTH'(EMPTY_THRES);

    wr_state_t             state_q;
    wr_state_t             state_d;
    logic [CHAN_WIDTH-1:0] chan_q;
    logic [CHAN_WIDTH-1:0] chan_d;

    logic [CHAN_QTY-1:0]   wr_sel;
    logic [CHAN_QTY-1:0]   rd_sel;
    logic [CHAN_QTY-1:0]   act_sel;
    logic [CHAN_QTY-1:0]   wr_en;
    logic [CHAN_QTY-1:0]   commit;
    logic [CHAN_QTY-1:0]   pop;

    logic                  wr_room;
    logic                  rd_has;
    logic                  rd_fire;
    logic                  ovf_inc;
    logic                  unf_inc;
    sb_t                   rd_head;

    sb_t                   head_data [CHAN_QTY];
    logic [CNT_WIDTH-1:0]  used      [CHAN_QTY];
`ifdef SD_FORWARD_MC_PRE_EN
    sb_t                   pre_data  [CHAN_QTY];
`endif

    for (genvar c = 0; c < CHAN_QTY; c++) begin : g_chan
        sd_desc_queue #(
            .DEPTH     (DEPTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_queue (
            .clk_wr    (clk_wr),
            .rst_n     (rst_n),
            .restart   (din_restart),
            .wr_en     (wr_en[c]),
            .wr_data   (din_sb),
            .commit    (commit[c]),
            .pop       (pop[c]),
            .head_data (head_data[c]),
`ifdef SD_FORWARD_MC_PRE_EN
            .pre_data  (pre_data[c]),
`endif
            .used      (used[c])
        );

        assign bloc_used[c*CNT_WIDTH +: CNT_WIDTH] = used[c];
        assign bloc_full[c]  = used[c] >= FULL_LVL;
        assign bloc_empty[c] = used[c] <= EMPTY_LVL;
    end

    // Decode write/read/open channels; out-of-range selects match nothing,
    // so they read as full on the write side and empty on the read side.
    always_comb begin
        wr_sel  = '0;
        rd_sel  = '0;
        act_sel = '0;
        wr_room = 1'b0;
        rd_has  = 1'b0;
        rd_head = '0;
        for (int c = 0; c < CHAN_QTY; c++) begin
            if (din_chan == CHAN_WIDTH'(c)) begin
                wr_sel[c] = 1'b1;
                wr_room   = used[c] < FULL_LVL;
            end
            if (dout_chan == CHAN_WIDTH'(c)) begin
                rd_sel[c] = 1'b1;
                rd_has    = used[c] != '0;
                rd_head   = head_data[c];
            end
            act_sel[c] = chan_q == CHAN_WIDTH'(c);
        end
    end

    assign din_ready = wr_room;

    // Write FSM: fullness is decided once at SOP, so EOP commits blindly.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        wr_en   = '0;
        commit  = '0;
        ovf_inc = 1'b0;
        if (din_valid) begin
            unique case (1'b1)
                din_sop: begin
                    if (wr_room) begin
                        wr_en   = wr_sel;
                        chan_d  = din_chan;
                        commit  = din_eop ? wr_sel : '0;
                        state_d = din_eop ? WR_IDLE : WR_ACTIVE;
                    end else begin
                        ovf_inc = din_eop;
                        state_d = din_eop ? WR_IDLE : WR_DISCARD;
                    end
                end
                (!din_sop && din_eop): begin
                    unique case (state_q)
                        WR_ACTIVE: begin
                            commit  = act_sel;
                            state_d = WR_IDLE;
                        end
                        WR_DISCARD: begin
                            ovf_inc = 1'b1;
                            state_d = WR_IDLE;
                        end
                        default: state_d = WR_IDLE;
                    endcase
                end
                default: ;
            endcase
        end
        if (din_restart) begin
            state_d = WR_IDLE;
            wr_en   = '0;
            commit  = '0;
            ovf_inc = 1'b0;
        end
    end

    // Read side: drop beats read, repeat reads without consuming.
    always_comb begin
        pop     = '0;
        rd_fire = 1'b0;
        unf_inc = 1'b0;
        if (dout_drop && rd_has) begin
            pop = rd_sel;
        end else if (dout_ready && rd_has) begin
            rd_fire = 1'b1;
            pop     = dout_repeat ? '0 : rd_sel;
        end
        if (dout_ready && !rd_has) unf_inc = 1'b1;
        if (din_restart) begin
            pop     = '0;
            rd_fire = 1'b0;
            unf_inc = 1'b0;
        end
    end

    // Write FSM state and the channel of the open packet.
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WR_IDLE;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
        end
    end

    // Registered read data; descriptor holds while no read fires.
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid  <= 1'b0;
            dout_sb     <= '0;
            dout_chan_o <= '0;
        end else begin
            dout_valid <= rd_fire;
            if (rd_fire) begin
                dout_sb     <= rd_head;
                dout_chan_o <= dout_chan;
            end
        end
    end

    // Wrapping event counters; restart leaves them alone.
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt  <= '0;
            underflow_cnt <= '0;
        end else begin
            if (ovf_inc) overflow_cnt <= overflow_cnt + 32'd1;
            if (unf_inc) underflow_cnt <= underflow_cnt + 32'd1;
        end
    end

`ifdef SD_FORWARD_MC_PRE_EN
    // Look-ahead mux: entry after the head of the selected read channel.
    always_comb begin
        dout_sb_pre = '0;
        for (int c = 0; c < CHAN_QTY; c++) begin
            if (dout_chan == CHAN_WIDTH'(c)) dout_sb_pre = pre_data[c];
        end
    end
`else
    assign dout_sb_pre = '0;
`endif

endmodule

// File: tb/tb_sd_forward_mc.sv
// Scoreboard bench for sd_forward_mc with default parameters.
// Reads push expected descriptors; a negedge monitor pops and compares.
module tb_sd_forward_mc;
    import sd_forward_pkg::*;

    localparam int CHW = 1;
    localparam int CW  = 3;

    logic           clk_wr = 1'b0;
    logic           rst_n = 1'b0;
    logic           din_restart = 1'b0;
    logic [CHW-1:0] din_chan = '0;
    logic           din_sop = 1'b0;
    logic           din_eop = 1'b0;
    logic           din_valid = 1'b0;
    sb_t            din_sb = '0;
    logic           din_ready;
    logic [CHW-1:0] dout_chan = '0;
    logic           dout_ready = 1'b0;
    logic           dout_drop = 1'b0;
    logic           dout_repeat = 1'b0;
    logic           dout_valid;
    sb_t            dout_sb;
    sb_t            dout_sb_pre;
    logic [CHW-1:0] dout_chan_o;
    logic [31:0]    overflow_cnt;
    logic [31:0]    underflow_cnt;
    logic [2*CW-1:0] bloc_used;
    logic [1:0]     bloc_full;
    logic [1:0]     bloc_empty;

    sd_forward_mc dut (
        .clk_wr        (clk_wr),
        .rst_n         (rst_n),
        .din_restart   (din_restart),
        .din_chan      (din_chan),
        .din_sop       (din_sop),
        .din_eop       (din_eop),
        .din_valid     (din_valid),
        .din_sb        (din_sb),
        .din_ready     (din_ready),
        .dout_chan     (dout_chan),
        .dout_ready    (dout_ready),
        .dout_drop     (dout_drop),
        .dout_repeat   (dout_repeat),
        .dout_valid    (dout_valid),
        .dout_sb       (dout_sb),
        .dout_sb_pre   (dout_sb_pre),
        .dout_chan_o   (dout_chan_o),
        .overflow_cnt  (overflow_cnt),
        .underflow_cnt (underflow_cnt),
        .bloc_used     (bloc_used),
        .bloc_full     (bloc_full),
        .bloc_empty    (bloc_empty)
    );

    always #5 clk_wr = ~clk_wr;

    int cyc = 0;
    always @(posedge clk_wr) cyc++;

    int checks = 0;
    int failures = 0;

    typedef struct {
        sb_t            sb;
        logic [CHW-1:0] ch;
        int             cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic sb_t mksb(input int e);
        sb_t s;
        s.exp    = 6'(e);
        s.symbol = 4'(e) ^ 4'h5;
        s.slot   = 8'(e + 48);
        s.frame  = 10'(e * 7);
        return s;
    endfunction

    function automatic logic [CW-1:0] used_of(input int c);
        return bloc_used[c*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge clk_wr);
        #1;
        din_valid   = 1'b0;
        din_sop     = 1'b0;
        din_eop     = 1'b0;
        din_restart = 1'b0;
        dout_ready  = 1'b0;
        dout_drop   = 1'b0;
        dout_repeat = 1'b0;
    endtask

    task automatic set_wr(input int ch, input bit sop, input bit eop,
                          input int e);
        din_valid = 1'b1;
        din_chan  = CHW'(ch);
        din_sop   = sop;
        din_eop   = eop;
        din_sb    = mksb(e);
    endtask

    task automatic set_rd(input int ch, input bit rep, input bit present,
                          input int e);
        dout_chan   = CHW'(ch);
        dout_ready  = 1'b1;
        dout_repeat = rep;
        if (present) sbq.push_back('{sb: mksb(e), ch: CHW'(ch), cyc: cyc});
    endtask

    task automatic pkt(input int ch, input int e);
        set_wr(ch, 1'b1, 1'b1, e);
        tick();
    endtask

    task automatic rd(input int ch, input int e);
        set_rd(ch, 1'b0, 1'b1, e);
        tick();
    endtask

    // Monitor: every presented descriptor must match the oldest request.
    always @(negedge clk_wr) begin
        if (rst_n && dout_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("dout_sb", dout_sb, mon_e.sb);
                chk("dout_chan_o", dout_chan_o, mon_e.ch);
                chk("rd_latency", cyc, mon_e.cyc + 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_wr);
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_sb", dout_sb, 0);
        chk("rst_dout_chan_o", dout_chan_o, 0);
        chk("rst_overflow", overflow_cnt, 0);
        chk("rst_underflow", underflow_cnt, 0);
        chk("rst_bloc_used", bloc_used, 0);
        chk("rst_bloc_full", bloc_full, 0);
        chk("rst_bloc_empty", bloc_empty, 2'b11);
        chk("rst_din_ready", din_ready, 1);
        rst_n = 1'b1;
        tick();

        // three single-beat packets on ch0, then drain
        pkt(0, 1);
        pkt(0, 2);
        pkt(0, 3);
        chk("t1_used_fill", used_of(0), 3);
        rd(0, 1);
        rd(0, 2);
        rd(0, 3);
        chk("t1_used_drain", used_of(0), 0);
        chk("t1_empty", bloc_empty[0], 1);

        // fill ch1 with two-beat packets, then overflow it
        for (int i = 0; i < 5; i++) begin
            set_wr(1, 1'b1, 1'b0, 10 + i);
            tick();
            set_wr(1, 1'b0, 1'b1, 10 + i);
            tick();
        end
        chk("t2_used1_full", used_of(1), 5);
        chk("t2_bloc_full", bloc_full, 2'b10);
        din_chan = 1'b1;
        #1;
        chk("t2_ready_ch1", din_ready, 0);
        din_chan = 1'b0;
        #1;
        chk("t2_ready_ch0", din_ready, 1);
        set_wr(1, 1'b1, 1'b0, 15);
        tick();
        set_wr(1, 1'b0, 1'b1, 15);
        tick();
        chk("t2_overflow", overflow_cnt, 1);
        chk("t2_used1_kept", used_of(1), 5);
        chk("t2_used0_clean", used_of(0), 0);
        for (int i = 0; i < 5; i++) rd(1, 10 + i);
        chk("t2_used1_drain", used_of(1), 0);

        // repeat reads do not consume; drop discards; empty read counts
        pkt(0, 7);
        pkt(0, 8);
        set_rd(0, 1'b1, 1'b1, 7);
        tick();
        set_rd(0, 1'b1, 1'b1, 7);
        tick();
        chk("t3_repeat_used", used_of(0), 2);
        dout_chan = 1'b0;
        dout_drop = 1'b1;
        tick();
        dout_drop = 1'b1;
        tick();
        chk("t3_drop_used", used_of(0), 0);
        set_rd(0, 1'b0, 1'b0, 0);
        tick();
        chk("t3_underflow", underflow_cnt, 1);

        // simultaneous commit and pop on ch0 across pointer wraps
        pkt(0, 20);
        pkt(0, 21);
        pkt(0, 22);
        for (int i = 0; i < 12; i++) begin
            set_wr(0, 1'b1, 1'b1, 23 + i);
            set_rd(0, 1'b0, 1'b1, 20 + i);
            tick();
            chk("t4_used_steady", used_of(0), 3);
        end
        for (int i = 0; i < 3; i++) rd(0, 32 + i);
        chk("t4_used_drain", used_of(0), 0);

        // restart mid-packet discards everything pending
        pkt(0, 41);
        set_wr(1, 1'b1, 1'b0, 40);
        tick();
        din_restart = 1'b1;
        tick();
        set_wr(1, 1'b0, 1'b1, 40);
        tick();
        chk("t5_used", bloc_used, 0);
        chk("t5_overflow", overflow_cnt, 1);
        chk("t5_empty", bloc_empty, 2'b11);
        pkt(1, 42);
        chk("t5_idle_commit", used_of(1), 1);
        rd(1, 42);

        // look-ahead output
        pkt(0, 4);
        pkt(0, 5);
        dout_chan = 1'b0;
        #1;
`ifdef SD_FORWARD_MC_PRE_EN
        chk("t6_pre", dout_sb_pre, mksb(5));
`else
        chk("t6_pre_off", dout_sb_pre, 0);
`endif
        rd(0, 4);
        rd(0, 5);

        repeat (3) tick();
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
